// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 32 register file.
// The optional REGFILE_BYPASS_EN macro enables same-cycle write-to-read forwarding.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    function automatic logic is_zero_reg(input reg_idx_t idx);
        return (idx == ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, register-0 forcing and optional bypass.
// Forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int P_DATA_W   = DATA_W,
    parameter int P_ADDR_W   = ADDR_W,
    parameter int P_NUM_REGS = NUM_REGS
) (
    input  logic [P_NUM_REGS-1:0][P_DATA_W-1:0] i_regs,
    input  logic [P_ADDR_W-1:0]                 i_rd_idx,
    input  logic                                i_wr_en,
    input  logic [P_ADDR_W-1:0]                 i_wr_idx,
    input  logic [P_DATA_W-1:0]                 i_wr_data,
    output logic [P_DATA_W-1:0]                 o_rd_data
);

`ifdef REGFILE_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    logic w_bypass_hit;

    // i_wr_en already folds in reset and the register-0 exclusion.
    assign w_bypass_hit = BYPASS_EN & i_wr_en & (i_wr_idx == i_rd_idx);

    // Read mux with register 0 forced to zero ahead of any forwarding.
    always_comb begin
        o_rd_data = {P_DATA_W{1'b0}};
        if (i_rd_idx == {P_ADDR_W{1'b0}}) begin
            o_rd_data = {P_DATA_W{1'b0}};
        end else if (w_bypass_hit) begin
            o_rd_data = i_wr_data;
        end else begin
            o_rd_data = i_regs[i_rd_idx];
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32 register file: two combinational read ports, one synchronous write port.
// Define REGFILE_BYPASS_EN to forward in-flight write data to the read ports.
module register_file
    import regfile_pkg::*;
#(
    parameter int P_DATA_W   = DATA_W,
    parameter int P_ADDR_W   = ADDR_W,
    parameter int P_NUM_REGS = NUM_REGS
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                regWrite,
    input  logic [P_ADDR_W-1:0] readReg1,
    input  logic [P_ADDR_W-1:0] readReg2,
    input  logic [P_ADDR_W-1:0] writeReg,
    input  logic [P_DATA_W-1:0] writeData,
    output logic [P_DATA_W-1:0] readData1,
    output logic [P_DATA_W-1:0] readData2
);

    logic [P_NUM_REGS-1:0][P_DATA_W-1:0] r_regs;
    logic                                w_wr_en;

    // A write commits only outside reset and never to register 0.
    assign w_wr_en = regWrite & ~Rst & (writeReg != {P_ADDR_W{1'b0}});

    // Storage update: reset clears every entry and wins over a pending write.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_regs <= '0;
        end else if (w_wr_en) begin
            r_regs[writeReg] <= writeData;
        end
    end

    regfile_read_port #(
        .P_DATA_W   (P_DATA_W),
        .P_ADDR_W   (P_ADDR_W),
        .P_NUM_REGS (P_NUM_REGS)
    ) u_read_port1 (
        .i_regs    (r_regs),
        .i_rd_idx  (readReg1),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (writeReg),
        .i_wr_data (writeData),
        .o_rd_data (readData1)
    );

    regfile_read_port #(
        .P_DATA_W   (P_DATA_W),
        .P_ADDR_W   (P_ADDR_W),
        .P_NUM_REGS (P_NUM_REGS)
    ) u_read_port2 (
        .i_regs    (r_regs),
        .i_rd_idx  (readReg2),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (writeReg),
        .i_wr_data (writeData),
        .o_rd_data (readData2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random traffic
// compared against an array model of the register file.
module tb_register_file;
    import regfile_pkg::*;

    logic      Clk;
    logic      Rst;
    logic      regWrite;
    reg_idx_t  readReg1;
    reg_idx_t  readReg2;
    reg_idx_t  writeReg;
    reg_data_t writeData;
    reg_data_t readData1;
    reg_data_t readData2;

    reg_data_t mdl [NUM_REGS];
    int        n_cmp;
    int        n_err;

    register_file dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .regWrite  (regWrite),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Value a read port should show right now, given committed model state.
    function automatic reg_data_t model_read(input reg_idx_t idx);
        if (idx == ZERO_REG) return 32'h0000_0000;
`ifdef REGFILE_BYPASS_EN
        if (regWrite && !Rst && writeReg != ZERO_REG && idx == writeReg) return writeData;
`endif
        return mdl[idx];
    endfunction

    task automatic check(input string tag, input reg_data_t obs, input reg_data_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_rd1"}, readData1, model_read(readReg1));
        check({tag, "_rd2"}, readData2, model_read(readReg2));
    endtask

    // One rising edge; the model commits what the inputs request at that edge.
    task automatic step();
        @(posedge Clk);
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'h0000_0000;
        end else if (regWrite && writeReg != ZERO_REG) begin
            mdl[writeReg] = writeData;
        end
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        Rst       = 1'b1;
        regWrite  = 1'b0;
        readReg1  = 5'd0;
        readReg2  = 5'd0;
        writeReg  = 5'd0;
        writeData = 32'h0000_0000;
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = 'x;

        // Register 0 reads zero even before any reset.
        #1;
        check("pre_reset_r0_rd1", readData1, 32'h0000_0000);
        check("pre_reset_r0_rd2", readData2, 32'h0000_0000);
        step();
        Rst = 1'b0;

        // After reset every index reads zero on both ports.
        for (int i = 0; i < NUM_REGS; i++) begin
            readReg1 = 5'(i);
            readReg2 = 5'(NUM_REGS - 1 - i);
            #1;
            check("reset_all_rd1", readData1, 32'h0000_0000);
            check("reset_all_rd2", readData2, 32'h0000_0000);
        end

        // Reset clears a previously written register.
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEAD_BEEF;
        step();
        regWrite = 1'b0; readReg1 = 5'd5; readReg2 = 5'd5;
        #1;
        check("pre_clear_r5", readData1, 32'hDEAD_BEEF);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        #1;
        check("clear_r5_rd1", readData1, 32'h0000_0000);
        check("clear_r5_rd2", readData2, 32'h0000_0000);

        // Basic write then read, including a combinational index change.
        readReg1 = 5'd8; readReg2 = 5'd10; writeReg = 5'd10;
        writeData = 32'h1111_2222; regWrite = 1'b0;
        step();
        step();
        check("basic_idle_rd1", readData1, 32'h0000_0000);
        check("basic_idle_rd2", readData2, 32'h0000_0000);
        regWrite = 1'b1;
        step();
        regWrite = 1'b0;
        #1;
        check("basic_wr_rd2", readData2, 32'h1111_2222);
        check("basic_wr_rd1", readData1, 32'h0000_0000);
        readReg1 = 5'd10;
        #1;
        check("basic_comb_rd1", readData1, 32'h1111_2222);

        // Write enable low leaves the target untouched.
        writeReg = 5'd3; writeData = 32'hAAAA_5555; regWrite = 1'b0;
        step(); step(); step();
        readReg1 = 5'd3;
        #1;
        check("we_low_r3", readData1, 32'h0000_0000);

        // Writes to register 0 are dropped, also same-cycle.
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFF_FFFF; readReg1 = 5'd0;
        #1;
        check("r0_same_cycle", readData1, 32'h0000_0000);
        step();
        regWrite = 1'b0;
        #1;
        check("r0_protected", readData1, 32'h0000_0000);

        // Reset wins over a write on the same edge.
        Rst = 1'b1; regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h1234_5678;
        step();
        Rst = 1'b0; regWrite = 1'b0; readReg1 = 5'd7;
        #1;
        check("rst_priority_r7", readData1, 32'h0000_0000);

        // Read-during-write on register 4, both ports aimed at it.
        readReg1 = 5'd4; readReg2 = 5'd4; writeReg = 5'd4;
        regWrite = 1'b1; writeData = 32'hCAFE_F00D;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before_rd1", readData1, 32'hCAFE_F00D);
        check("rdw_before_rd2", readData2, 32'hCAFE_F00D);
`else
        check("rdw_before_rd1", readData1, 32'h0000_0000);
        check("rdw_before_rd2", readData2, 32'h0000_0000);
`endif
        step();
        regWrite = 1'b0;
        #1;
        check("rdw_after_rd1", readData1, 32'hCAFE_F00D);
        check("rdw_after_rd2", readData2, 32'hCAFE_F00D);

        // Random traffic; reads sometimes aimed at the write target.
        for (int n = 0; n < 600; n++) begin
            Rst       = ($urandom_range(0, 39) == 0);
            regWrite  = ($urandom_range(0, 2) != 0);
            writeReg  = 5'($urandom_range(0, NUM_REGS - 1));
            writeData = $urandom;
            readReg1  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, NUM_REGS - 1));
            readReg2  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, NUM_REGS - 1));
            #1;
            check_ports("rand_pre");
            step();
            check_ports("rand_post");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
